// File: rtl/comp_seq_nbit.sv
// comp_seq_nbit: multi-cycle N-bit magnitude comparator, MS chunk first.
// A start/busy/done handshake returns less-than / greater-than / equal,
// held until the next done. Signed mode applies an offset-binary transform
// to the captured operands.
// Optional build macro: COMP_EARLY_EXIT_EN (finish at the first differing chunk).
module comp_seq_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             a_less_b,
    output logic             a_greater_b,
    output logic             equal
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             less_q, less_d;
    logic             greater_q, greater_d;
    logic             equal_q, equal_d;

    logic [CHUNK-1:0] chunk_a_c;
    logic [CHUNK-1:0] chunk_b_c;
    logic             diff_c;
    logic             dec_now_c;
    logic             lt_now_c;
    logic             last_c;
    logic             finish_c;

    // Current chunk pair and the running (sticky) decision including this chunk
    assign chunk_a_c = a_q[32'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b_c = b_q[32'(idx_q) * CHUNK +: CHUNK];
    assign diff_c    = (chunk_a_c != chunk_b_c);
    assign dec_now_c = decided_q | diff_c;
    assign lt_now_c  = decided_q ? lt_q : (chunk_a_c < chunk_b_c);
    assign last_c    = (idx_q == IDX_W'(0));

    // Scan termination: last chunk, or first difference when early exit is built in
`ifdef COMP_EARLY_EXIT_EN
    assign finish_c  = last_c | (~decided_q & diff_c);
`else
    assign finish_c  = last_c;
`endif

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        less_d    = less_q;
        greater_d = greater_q;
        equal_d   = equal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = in1;
                    b_d = in2;
                    // Flipping the sign bit maps two's-complement order onto unsigned order
                    if (signed_mode) begin
                        a_d[WIDTH-1] = ~in1[WIDTH-1];
                        b_d[WIDTH-1] = ~in2[WIDTH-1];
                    end
                    idx_d     = IDX_LAST;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                decided_d = dec_now_c;
                lt_d      = lt_now_c;
                if (finish_c) begin
                    less_d    = dec_now_c & lt_now_c;
                    greater_d = dec_now_c & ~lt_now_c;
                    equal_d   = ~dec_now_c;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            less_q    <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            less_q    <= less_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign a_less_b    = less_q;
    assign a_greater_b = greater_q;
    assign equal       = equal_q;

endmodule

// File: tb/tb_comp_seq_nbit.sv
// Self-checking bench for comp_seq_nbit (WIDTH=16, CHUNK=4): directed cases plus
// random compares against a plain-arithmetic reference model.
module tb_comp_seq_nbit;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             signed_mode = 1'b0;
    logic             busy, done, a_less_b, a_greater_b, equal;

    int n_checks = 0;
    int n_fail   = 0;

    comp_seq_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .a_less_b(a_less_b), .a_greater_b(a_greater_b), .equal(equal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {lt, gt, eq} from ordinary integer ordering
    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sm);
        logic lt, gt;
        if (sm) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return {lt, gt, (a == b)};
    endfunction

    // Reference latency in cycles from the accepting edge to done
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMP_EARLY_EXIT_EN
        for (int i = 0; i < NCHUNK; i++) begin
            int sh;
            sh = WIDTH - CHUNK * (i + 1);
            if (((a >> sh) & 16'hF) != ((b >> sh) & 16'hF)) return i + 1;
        end
        return NCHUNK;
`else
        return NCHUNK;
`endif
    endfunction

    function automatic logic [2:0] res_now();
        return {a_less_b, a_greater_b, equal};
    endfunction

    // One full compare; optionally disturbs start/operands while busy
    task automatic do_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input bit disturb);
        int cycles;
        logic [2:0] exp_r;
        exp_r = ref_res(a, b, sm);
        in1 = a; in2 = b; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 20) begin
            if (disturb) begin
                start = 1'($urandom);
                in1 = 16'($urandom);
                in2 = 16'($urandom);
                signed_mode = 1'($urandom);
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(cycles), 32'(ref_lat(a, b)));
        chk({tag, "_result"}, 32'(res_now()), 32'(exp_r));
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
        chk({tag, "_held"}, 32'(res_now()), 32'(exp_r));
    endtask

    initial begin
        logic [2:0] exp_r;
        int cycles;
        int lat1;

        // Reset state
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk("reset_outs", 32'({busy, done, a_less_b, a_greater_b, equal}), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_pre_done", 32'({busy, done, a_less_b, a_greater_b, equal}), 32'd0);

        // T1: equal operands
        do_cmp("t1_equal", 16'h1234, 16'h1234, 1'b0, 1'b0);
        // T2: sign bit effect
        do_cmp("t2_unsigned", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        do_cmp("t2_signed", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        // T3: MS-chunk difference and LS-chunk difference
        do_cmp("t3_msb_diff", 16'hA000, 16'h1000, 1'b0, 1'b0);
        do_cmp("t3_lsb_diff", 16'h1230, 16'h1234, 1'b0, 1'b0);
        // T4: start and operand changes while busy are ignored
        do_cmp("t4_busy_start", 16'h0001, 16'h0002, 1'b0, 1'b1);

        // T5: reset during the second SCAN cycle
        in1 = 16'h1230; in2 = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_reset_abort", 32'({busy, done, a_less_b, a_greater_b, equal}), 32'd0);
        cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) cycles++;
        end
        chk("t5_no_done", 32'(cycles), 32'd0);
        do_cmp("t5_after", 16'h4321, 16'h1234, 1'b0, 1'b0);

        // T6: start held through done gives back-to-back compares
        in1 = 16'hFFFF; in2 = 16'h0000; signed_mode = 1'b1; start = 1'b1;
        exp_r = ref_res(16'hFFFF, 16'h0000, 1'b1);
        lat1 = ref_lat(16'hFFFF, 16'h0000);
        tick();
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        chk("t6_first_lat", 32'(cycles), 32'(lat1));
        chk("t6_first_res", 32'(res_now()), 32'(exp_r));
        tick();
        chk("t6_reaccept", 32'({busy, done}), 32'b10);
        chk("t6_held", 32'(res_now()), 32'(exp_r));
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        chk("t6_second_lat", 32'(cycles), 32'(lat1));
        chk("t6_second_res", 32'(res_now()), 32'(exp_r));
        tick();

        // Random compares; some share upper chunks to exercise late decisions
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[15:4], b[3:0]};
                2: b = {a[15:8], b[7:0]};
                default: ;
            endcase
            do_cmp($sformatf("rnd%0d", i), a, b, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
